// File: rtl/tw_power_gen.sv
// Twiddle power generator: emits base*step^k mod p (p = 2^64-2^32+1) on two 64-bit lanes.
// Optional `TW_GEN_IDX_EN adds a tw_idx output carrying k alongside tw_out.
module tw_power_gen #(
  parameter int DW      = 64,
  parameter int CNT_W   = 5,
  parameter int MUL_LAT = 3
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*DW-1:0]   tw_base,
  input  logic [2*DW-1:0]   tw_step,
  input  logic [CNT_W-1:0]  n_pow,
  output logic [2*DW-1:0]   tw_out,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output logic              done
`ifdef TW_GEN_IDX_EN
  ,
  output logic [CNT_W-1:0]  tw_idx
`endif
);

  localparam logic [63:0] P   = 64'hFFFF_FFFF_0000_0001;
  localparam logic [63:0] EPS = 64'h0000_0000_FFFF_FFFF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  function automatic logic [63:0] gl_canon(input logic [63:0] a);
    return (a >= P) ? a - P : a;
  endfunction

  // Goldilocks reduction of the full 128-bit product, using 2^64 = 2^32-1 and 2^96 = -1 (mod p).
  function automatic logic [63:0] gl_mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] x;
    logic [64:0]  d;
    logic [64:0]  s;
    logic [63:0]  m;
    logic [63:0]  t;
    x = {64'd0, a} * {64'd0, b};
    d = {1'b0, x[63:0]} - {33'd0, x[127:96]};
    t = d[63:0];
    if (d[64]) t = t - EPS;
    m = {x[95:64], 32'd0} - {32'd0, x[95:64]};
    s = {1'b0, t} + {1'b0, m};
    t = s[63:0];
    if (s[64]) t = t + EPS;
    if (t >= P) t = t - P;
    return t;
  endfunction

  logic [2:0]          r_state;
  logic [2*DW-1:0]     r_acc;
  logic [2*DW-1:0]     r_step;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DW-1:0]     r_out;
  logic                r_vld;
  logic [MUL_LAT-1:0]  r_pvld;
  logic [2*DW-1:0]     r_pipe [MUL_LAT];

  logic [2*DW-1:0]     w_prod;
  logic                w_issue;
  logic                w_prod_rdy;

  // acc is stable while a multiply is in flight, so the product can be formed straight from it.
  assign w_prod     = {gl_mulmod(r_acc[127:64], r_step[127:64]),
                       gl_mulmod(r_acc[63:0],   r_step[63:0])};
  assign w_issue    = (r_state == S_EMIT) && out_rdy && (r_cnt != CNT_W'(1));
  assign w_prod_rdy = (r_state == S_MUL) && r_pvld[MUL_LAT-1];

  assign tw_out  = r_out;
  assign out_vld = r_vld;
  assign busy    = (r_state == S_LOAD) || (r_state == S_EMIT) || (r_state == S_MUL);
  assign done    = (r_state == S_FIN);

  // NOTE: the product data pipe carries no reset; only its valid bits do, so stale data is never consumed.
  always_ff @(posedge CLK) begin
    r_pipe[0] <= w_prod;
    for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end

  // NOTE: all state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_vld   <= 1'b0;
      r_pvld  <= '0;
    end else begin
      r_pvld <= (r_pvld << 1) | MUL_LAT'(w_issue);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= {gl_canon(tw_base[127:64]), gl_canon(tw_base[63:0])};
            r_step  <= {gl_canon(tw_step[127:64]), gl_canon(tw_step[63:0])};
            r_cnt   <= n_pow;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_cnt == '0) begin
            r_state <= S_FIN;
          end else begin
            r_out   <= r_acc;
            r_vld   <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_rdy) begin
            r_vld   <= 1'b0;
            r_cnt   <= r_cnt - CNT_W'(1);
            r_state <= (r_cnt == CNT_W'(1)) ? S_FIN : S_MUL;
          end
        end
        S_MUL: begin
          if (w_prod_rdy) begin
            r_acc   <= r_pipe[MUL_LAT-1];
            r_out   <= r_pipe[MUL_LAT-1];
            r_vld   <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TW_GEN_IDX_EN
  logic [CNT_W-1:0] r_idx;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)                 r_idx <= '0;
    else if (r_state == S_LOAD) r_idx <= '0;
    else if (w_prod_rdy)        r_idx <= r_idx + CNT_W'(1);
  end

  assign tw_idx = r_idx;
`endif

endmodule
